// File: rtl/debug_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debug_scan_pkg
// Description : Shared state encoding and default widths for the debug scan
//               master and its step-pacing counter.
// Revision    : 1.0 - initial release
// ============================================================================
package debug_scan_pkg;

   localparam int DEFAULT_DR_WIDTH = 38;
   localparam int DEFAULT_IR_WIDTH = 2;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_UIR  = 3'd1,
      ST_CDR  = 3'd2,
      ST_SDR  = 3'd3,
      ST_UDR  = 3'd4,
      ST_RTI  = 3'd5,
      ST_RESP = 3'd6
   } scan_state_e;

   // True for the states that are paced by scan steps (UIR through RTI).
   function automatic logic is_scan_active(input scan_state_e s);
      return (s == ST_UIR) || (s == ST_CDR) || (s == ST_SDR) ||
             (s == ST_UDR) || (s == ST_RTI);
   endfunction

endpackage
`default_nettype wire

// File: rtl/debug_scan_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : debug_scan_tick_gen
// Description : Step-pacing counter. Tracks the position of the current clk
//               inside a CLK_DIV-long scan step and flags, one cycle ahead,
//               that the coming cycle is the last one of a step so the
//               master can register its step strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module debug_scan_tick_gen
   import debug_scan_pkg::*;
#(
   parameter int CLK_DIV = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,    // a new scan starts next cycle at step position 0
   input  logic enable,   // next cycle belongs to an active scan
   output logic tick      // next cycle is the last clk of a scan step
);

   localparam logic [7:0] C_LAST = 8'(CLK_DIV - 1);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;
   logic [7:0] pos_next;

   // Position of the next cycle within its step; wraps at the end of a step.
   always_comb begin
      pos_next = '0;
      if (!clear && (cnt_q != C_LAST)) begin
         pos_next = cnt_q + 8'd1;
      end
      cnt_d = enable ? pos_next : 8'd0;
      tick  = enable && (pos_next == C_LAST);
   end

   // Step position register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/debug_scan_master.sv
`default_nettype none
// ============================================================================
// Module      : debug_scan_master
// Description : Runs one virtual-JTAG style scan per command: update-IR,
//               capture-DR, DR_WIDTH shift-DR steps (LSB first, tdo captured
//               into the top of the shift register), update-DR and
//               run-test-idle, then holds the captured data as a response.
//               Every output comes straight from a flop.
// Revision    : 1.0 - initial release
// ============================================================================
module debug_scan_master
   import debug_scan_pkg::*;
#(
   parameter int DR_WIDTH = DEFAULT_DR_WIDTH,
   parameter int IR_WIDTH = DEFAULT_IR_WIDTH,
   parameter int CLK_DIV  = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [IR_WIDTH-1:0] cmd_ir,
   input  logic [DR_WIDTH-1:0] cmd_dr,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DR_WIDTH-1:0] rsp_dr,
   output logic [IR_WIDTH-1:0] ir_in,
   output logic                vs_uir,
   output logic                vs_cdr,
   output logic                vs_sdr,
   output logic                vs_udr,
   output logic                jtag_state_rti,
   output logic                tdi,
   input  logic                tdo,
   output logic                tck_en
);

   localparam int CW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
   localparam logic [CW-1:0] C_BIT_LAST = CW'(DR_WIDTH - 1);

   scan_state_e         state_q, state_d;
   logic [DR_WIDTH-1:0] sr_q, sr_d;
   logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
   logic                cmd_ready_q, cmd_ready_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                tdi_q, tdi_d;
   logic                tck_en_q;
   logic                vs_uir_q, vs_uir_d;
   logic                vs_cdr_q, vs_cdr_d;
   logic                vs_sdr_q, vs_sdr_d;
   logic                vs_udr_q, vs_udr_d;
   logic                rti_q, rti_d;
   logic                accept;
   logic                active_next;
   logic                tick_next;

   // tck_en_q marks the last clk of the current step; tick_next the next one.
   debug_scan_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_gen (
      .clk    (clk),
      .reset  (reset),
      .clear  (accept),
      .enable (active_next),
      .tick   (tick_next)
   );

   // Next-state, shift register and bit counter; steps advance on tck_en_q.
   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      bit_cnt_d = bit_cnt_q;
      accept    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               accept    = 1'b1;
               state_d   = ST_UIR;
               sr_d      = cmd_dr;
               bit_cnt_d = '0;
            end
         end
         ST_UIR: if (tck_en_q) state_d = ST_CDR;
         ST_CDR: if (tck_en_q) state_d = ST_SDR;
         ST_SDR: begin
            if (tck_en_q) begin
               sr_d = DR_WIDTH'({tdo, sr_q} >> 1);
               if (bit_cnt_q == C_BIT_LAST) begin
                  state_d = ST_UDR;
               end else begin
                  bit_cnt_d = bit_cnt_q + CW'(1);
               end
            end
         end
         ST_UDR:  if (tck_en_q) state_d = ST_RTI;
         ST_RTI:  if (tck_en_q) state_d = ST_RESP;
         ST_RESP: if (rsp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Registered outputs are derived from the next state so they line up with it.
   always_comb begin
      active_next = is_scan_active(state_d);
      ir_in_d     = '0;
      if (active_next) begin
         ir_in_d = accept ? cmd_ir : ir_in_q;
      end
      cmd_ready_d = (state_d == ST_IDLE);
      rsp_valid_d = (state_d == ST_RESP);
      tdi_d       = (state_d == ST_SDR) ? sr_d[0] : 1'b0;
      vs_uir_d    = tick_next && (state_d == ST_UIR);
      vs_cdr_d    = tick_next && (state_d == ST_CDR);
      vs_sdr_d    = tick_next && (state_d == ST_SDR);
      vs_udr_d    = tick_next && (state_d == ST_UDR);
      rti_d       = tick_next && (state_d == ST_RTI);
   end

   // State register; reset drops any scan in flight without a response.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr_q        <= '0;
         bit_cnt_q   <= '0;
         ir_in_q     <= '0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         tdi_q       <= 1'b0;
         tck_en_q    <= 1'b0;
         vs_uir_q    <= 1'b0;
         vs_cdr_q    <= 1'b0;
         vs_sdr_q    <= 1'b0;
         vs_udr_q    <= 1'b0;
         rti_q       <= 1'b0;
      end else begin
         sr_q        <= sr_d;
         bit_cnt_q   <= bit_cnt_d;
         ir_in_q     <= ir_in_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         tdi_q       <= tdi_d;
         tck_en_q    <= tick_next;
         vs_uir_q    <= vs_uir_d;
         vs_cdr_q    <= vs_cdr_d;
         vs_sdr_q    <= vs_sdr_d;
         vs_udr_q    <= vs_udr_d;
         rti_q       <= rti_d;
      end
   end

   assign cmd_ready      = cmd_ready_q;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_dr         = sr_q;
   assign ir_in          = ir_in_q;
   assign tdi            = tdi_q;
   assign tck_en         = tck_en_q;
   assign vs_uir         = vs_uir_q;
   assign vs_cdr         = vs_cdr_q;
   assign vs_sdr         = vs_sdr_q;
   assign vs_udr         = vs_udr_q;
   assign jtag_state_rti = rti_q;

endmodule
`default_nettype wire

// File: doc/debug_scan_master.md
DEBUG_SCAN_MASTER -- requirements
Module: debug_scan_master

Interface
REQ-001 Parameter DR_WIDTH, default 38, SHALL set the data-register scan length in bits.
REQ-002 Parameter IR_WIDTH, default 2, SHALL set the instruction width.
REQ-003 Parameter CLK_DIV, default 1, range 1..255, SHALL set the clk cycles per scan step.
REQ-004 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port cmd_valid, input, 1: a scan command is offered.
REQ-007 Port cmd_ready, output, 1: the block accepts a command this cycle.
REQ-008 Port cmd_ir, input, IR_WIDTH: the instruction to apply.
REQ-009 Port cmd_dr, input, DR_WIDTH: the data to shift out, LSB first.
REQ-010 Port rsp_valid, output, 1: captured scan data is available.
REQ-011 Port rsp_ready, input, 1: the consumer takes the response.
REQ-012 Port rsp_dr, output, DR_WIDTH: the bits captured from tdo.
REQ-013 Port ir_in, output, IR_WIDTH: the instruction presented to the debug slave.
REQ-014 Ports vs_uir, vs_cdr, vs_sdr, vs_udr, output, 1 each: the virtual-state update-IR, capture-DR, shift-DR and update-DR strobes.
REQ-015 Port jtag_state_rti, output, 1: run-test-idle indication.
REQ-016 Port tdi, output, 1: the serial data sent to the slave.
REQ-017 Port tdo, input, 1: the serial data returned by the slave.
REQ-018 Port tck_en, output, 1: a one-clk pulse that marks each scan step.

Function
REQ-019 States SHALL be IDLE, UIR, CDR, SDR, UDR, RTI and RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-020 Accepting a command (cmd_valid and cmd_ready in cycle N) SHALL latch cmd_ir and cmd_dr into the shift register, clear the step counter, and enter UIR at N+1.
REQ-021 Each of UIR, CDR, UDR and RTI SHALL last exactly CLK_DIV clk cycles, and SDR SHALL last DR_WIDTH*CLK_DIV cycles.
REQ-022 tck_en SHALL pulse in the last clk of every step.
REQ-023 The state's strobe (vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti) SHALL be asserted only in the tck_en cycles of that state.
REQ-024 ir_in SHALL equal the latched cmd_ir from UIR through RTI, and SHALL be 0 in IDLE and RESP.
REQ-025 tdi SHALL equal sr[0] throughout SDR and SHALL be 0 otherwise.
REQ-026 On every SDR tck_en, sr SHALL update to {tdo, sr[DR_WIDTH-1:1]}, where tdo is sampled in that same cycle.
REQ-027 The bit counter SHALL count 0..DR_WIDTH-1; SDR SHALL exit to UDR on the tck_en where count = DR_WIDTH-1.
REQ-028 RESP SHALL be entered at cycle N+1+(DR_WIDTH+4)*CLK_DIV (N+43 at defaults).
REQ-029 In RESP, rsp_valid=1 and rsp_dr=sr, both held stable until rsp_ready.
REQ-030 When rsp_valid and rsp_ready are both 1, the block SHALL return to IDLE next cycle; the minimum command-to-command gap is therefore one IDLE cycle.
REQ-031 cmd_valid outside IDLE SHALL be ignored, with no state change.
REQ-032 rsp_ready outside RESP SHALL be ignored.
REQ-033 CLK_DIV=1 SHALL make tck_en high on every cycle of an active scan.

Reset
REQ-034 On reset assertion, state SHALL go to IDLE immediately, asynchronously, including mid-scan.
REQ-035 On reset assertion, the following SHALL be set to 0: sr, step counter, bit counter, ir_in, tdi, all strobes, jtag_state_rti, tck_en and rsp_valid.
REQ-036 On reset assertion, cmd_ready SHALL be 1.
REQ-037 A scan interrupted by reset SHALL NOT produce a response, and no vs_udr SHALL be issued for it.
REQ-038 The first command SHALL be accepted on the first clk edge after reset deasserts.

Structure
REQ-039 The state enumeration and the DR_WIDTH/IR_WIDTH defaults SHALL live in the shared package debug_scan_pkg.
REQ-040 The step-pacing counter SHALL be the sub-module debug_scan_tick_gen.
REQ-041 debug_scan_tick_gen SHALL have inputs clk, reset, clear and enable, and output tick.
REQ-042 All outputs of debug_scan_master SHALL be registered.

Verification
REQ-043 Defaults; cmd_ir=2'b01, cmd_dr=38'h2A_5A5A_5A5A; tdo looped to tdi -> vs_uir at N+1, vs_cdr at N+2, 38 vs_sdr N+3..N+40, vs_udr N+41, rti N+42, rsp_valid N+43, rsp_dr=38'h2A_5A5A_5A5A.
REQ-044 tdo tied 1, cmd_dr=0 -> tdi observed 0 for 38 steps; rsp_dr=38'h3F_FFFF_FFFF.
REQ-045 CLK_DIV=3 -> each strobe is one clk wide, spaced 3 clks apart; rsp_valid at N+1+126.
REQ-046 Reset asserted at the 10th SDR step -> all outputs 0 same cycle, cmd_ready=1; no rsp_valid and no vs_udr afterwards.
REQ-047 rsp_ready held low 20 cycles, cmd_valid held high -> rsp_dr stable and no second accept; rsp_ready high -> IDLE, then next accept one cycle later.
